// File: rtl/drp_rmw_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | drp_rmw_master: command/response DRP master with masked RMW, timeout |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module drp_rmw_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 9
) (
    input  logic              drp_clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_rmw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_wdata,
    input  logic [15:0]       cmd_mask,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              drpen_o,
    output logic              drpwe_o,
    output logic [ADDR_W-1:0] drpaddr_o,
    output logic [15:0]       drpdi_o,
    input  logic              drprdy_i,
    input  logic [15:0]       drpdo_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_WAIT = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    // Counter value seen in the last allowed wait cycle (counter starts at 0).
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [15:0]       wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       di_q;
    logic [15:0]       wdata_q;
    logic [15:0]       mask_q;
    logic [15:0]       rsp_data_q;
    logic              is_rmw_q;
    logic              timeout_q;
    logic              accept;
    logic              wait_last;

    assign accept    = cmd_valid & cmd_ready;
    assign wait_last = (wait_cnt == CNT_LAST);

    always_ff @(posedge drp_clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (cmd_write && !cmd_rmw) ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_RD_REQ:  state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                if (drprdy_i) begin
                    state_nxt = is_rmw_q ? S_WR_REQ : S_RESP;
                end else if (wait_last) begin
                    state_nxt = S_RESP;
                end
            end
            S_WR_REQ:  state_nxt = S_WR_WAIT;
            S_WR_WAIT: begin
                if (drprdy_i || wait_last) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = (state == S_IDLE) && !reset;
        busy        = !cmd_ready;
        drpen_o     = (state == S_RD_REQ) || (state == S_WR_REQ);
        drpwe_o     = (state == S_WR_REQ);
        rsp_valid   = (state == S_RESP);
        rsp_timeout = (state == S_RESP) && timeout_q;
        rsp_rdata   = (state == S_RESP) ? rsp_data_q : 16'h0000;
        drpaddr_o   = addr_q;
        drpdi_o     = di_q;
    end

    always_ff @(posedge drp_clk) begin
        if (reset) begin
            wait_cnt   <= '0;
            addr_q     <= '0;
            di_q       <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            rsp_data_q <= '0;
            is_rmw_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= cmd_addr;
                wdata_q    <= cmd_wdata;
                mask_q     <= cmd_mask;
                is_rmw_q   <= cmd_write & cmd_rmw;
                di_q       <= (cmd_write && !cmd_rmw) ? cmd_wdata : 16'h0000;
                rsp_data_q <= '0;
                timeout_q  <= 1'b0;
            end
            case (state)
                S_RD_REQ, S_WR_REQ: wait_cnt <= '0;
                S_RD_WAIT: begin
                    if (drprdy_i) begin
                        // RMW merges into the write register so drpdi_o is ready for WR_REQ.
                        if (is_rmw_q) begin
                            di_q <= (drpdo_i & ~mask_q) | (wdata_q & mask_q);
                        end else begin
                            rsp_data_q <= drpdo_i;
                        end
                    end else if (wait_last) begin
                        timeout_q  <= 1'b1;
                        rsp_data_q <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_WR_WAIT: begin
                    if (drprdy_i) begin
                        rsp_data_q <= di_q;
                    end else if (wait_last) begin
                        timeout_q  <= 1'b1;
                        rsp_data_q <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_drp_rmw_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_drp_rmw_master: directed bench with a one-register DRP responder  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_drp_rmw_master;

    localparam int TIMEOUT_CYCLES = 16;
    localparam int ADDR_W         = 9;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic              cmd_rmw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_wdata;
    logic [15:0]       cmd_mask;
    logic              rsp_valid;
    logic [15:0]       rsp_rdata;
    logic              rsp_timeout;
    logic              busy;
    logic              drpen_o;
    logic              drpwe_o;
    logic [ADDR_W-1:0] drpaddr_o;
    logic [15:0]       drpdi_o;
    wire logic         drprdy_i;
    logic [15:0]       drpdo_i;

    logic model_rdy;
    logic stray_rdy;
    assign drprdy_i = model_rdy | stray_rdy;

    int checks;
    int errors;
    int cyc;
    int rdy_delay;
    int countdown;
    int en_cnt, we_cnt, en_cyc, prev_en_cyc;
    int rsp_cnt, rsp_cyc, acc_cnt, viol;
    logic [15:0]       model_data;
    logic [15:0]       last_di;
    logic [ADDR_W-1:0] last_addr;
    logic [15:0]       got_data;
    logic              got_to;

    drp_rmw_master #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ADDR_W(ADDR_W)) dut (
        .drp_clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_rmw(cmd_rmw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout), .busy(busy),
        .drpen_o(drpen_o), .drpwe_o(drpwe_o), .drpaddr_o(drpaddr_o), .drpdi_o(drpdi_o),
        .drprdy_i(drprdy_i), .drpdo_i(drpdo_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        acc_cnt = 0;
    end
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cmd_valid && cmd_ready) acc_cnt = acc_cnt + 1;
    end

    // DRP responder: one storage register, ready after rdy_delay cycles (0 = never).
    initial begin
        model_rdy = 1'b0; drpdo_i = 16'hFFFF; countdown = 0;
        en_cnt = 0; we_cnt = 0; en_cyc = 0; prev_en_cyc = 0;
        model_data = 16'h1234; last_di = '0; last_addr = '0;
        rsp_cnt = 0; rsp_cyc = 0; viol = 0; got_data = '0; got_to = 1'b0;
    end
    always @(negedge clk) begin
        model_rdy = 1'b0;
        drpdo_i   = 16'hFFFF;
        if (countdown > 0) begin
            countdown = countdown - 1;
            if (countdown == 0) begin
                model_rdy = 1'b1;
                drpdo_i   = model_data;
            end
        end
        if (drpen_o === 1'b1) begin
            en_cnt = en_cnt + 1;
            prev_en_cyc = en_cyc;
            en_cyc = cyc;
            last_addr = drpaddr_o;
            if (drpwe_o === 1'b1) begin
                we_cnt = we_cnt + 1;
                last_di = drpdi_o;
                model_data = drpdi_o;
            end
            countdown = rdy_delay;
        end
        if (rsp_valid === 1'b1) begin
            rsp_cnt = rsp_cnt + 1;
            rsp_cyc = cyc;
            got_data = rsp_rdata;
            got_to = rsp_timeout;
        end
        if (!reset && (cmd_ready === busy)) viol = viol + 1;
        if ((rsp_valid || drpen_o) && cmd_ready) viol = viol + 1;
    end

    task automatic issue(input logic wr, input logic rmw, input logic [ADDR_W-1:0] a,
                         input logic [15:0] wd, input logic [15:0] m);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_write = wr; cmd_rmw = rmw; cmd_addr = a; cmd_wdata = wd; cmd_mask = m;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = 16'hDEAD; cmd_mask = 16'hBEEF; cmd_addr = '1;
    endtask

    task automatic wait_rsp(input int start);
        int i;
        i = 0;
        while (rsp_cnt <= start && i < 100) begin
            @(posedge clk);
            i++;
        end
        checks++;
        if (rsp_cnt <= start) begin
            errors++;
            $display("FAIL rsp_wait: got no response within %0d cycles, required one", i);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
        checks++;
        if ({drpen_o, drpwe_o, rsp_valid, rsp_timeout} !== 4'b0) begin
            errors++; $display("FAIL rst_strobes: got %b want 0000", {drpen_o, drpwe_o, rsp_valid, rsp_timeout});
        end
        checks++;
        if ({drpaddr_o, drpdi_o, rsp_rdata} !== '0) begin
            errors++; $display("FAIL rst_data: got %h/%h/%h want 0", drpaddr_o, drpdi_o, rsp_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_release: got ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_read;
        int s, e, w;
        s = rsp_cnt; e = en_cnt; w = we_cnt;
        rdy_delay = 3;
        issue(1'b0, 1'b0, 9'h09E, 16'h5555, 16'hFFFF);
        wait_rsp(s);
        checks++;
        if (rsp_cyc - en_cyc !== 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", rsp_cyc - en_cyc); end
        checks++;
        if (got_data !== 16'h1234 || got_to !== 1'b0) begin
            errors++; $display("FAIL rd_data: got %h to=%b want 1234 to=0", got_data, got_to);
        end
        checks++;
        if (last_addr !== 9'h09E || en_cnt - e !== 1 || we_cnt - w !== 0) begin
            errors++; $display("FAIL rd_pulses: got addr=%h en=%0d we=%0d want 09e 1 0", last_addr, en_cnt - e, we_cnt - w);
        end
    endtask

    task automatic test_write;
        int s, e, w;
        s = rsp_cnt; e = en_cnt; w = we_cnt;
        rdy_delay = 1;
        issue(1'b1, 1'b0, 9'h03D, 16'h0080, 16'h0000);
        wait_rsp(s);
        checks++;
        if (rsp_cyc - en_cyc !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", rsp_cyc - en_cyc); end
        checks++;
        if (got_data !== 16'h0080 || got_to !== 1'b0 || last_di !== 16'h0080) begin
            errors++; $display("FAIL wr_data: got rsp=%h di=%h to=%b want 0080 0080 0", got_data, last_di, got_to);
        end
        checks++;
        if (last_addr !== 9'h03D || en_cnt - e !== 1 || we_cnt - w !== 1) begin
            errors++; $display("FAIL wr_pulses: got addr=%h en=%0d we=%0d want 03d 1 1", last_addr, en_cnt - e, we_cnt - w);
        end
    endtask

    task automatic test_rmw;
        int s, e, w;
        s = rsp_cnt;
        rdy_delay = 2;
        issue(1'b1, 1'b0, 9'h03D, 16'hABCD, 16'h0000);
        wait_rsp(s);
        s = rsp_cnt; e = en_cnt; w = we_cnt;
        rdy_delay = 1;
        issue(1'b1, 1'b1, 9'h03D, 16'h0050, 16'h00F0);
        wait_rsp(s);
        checks++;
        if (got_data !== 16'hAB5D || last_di !== 16'hAB5D || got_to !== 1'b0) begin
            errors++; $display("FAIL rmw_data: got rsp=%h di=%h to=%b want ab5d ab5d 0", got_data, last_di, got_to);
        end
        checks++;
        if (en_cnt - e !== 2 || we_cnt - w !== 1) begin
            errors++; $display("FAIL rmw_pulses: got en=%0d we=%0d want 2 1", en_cnt - e, we_cnt - w);
        end
        checks++;
        if (en_cyc - prev_en_cyc !== 2 || rsp_cyc - prev_en_cyc !== 4) begin
            errors++; $display("FAIL rmw_timing: got gap=%0d lat=%0d want 2 4", en_cyc - prev_en_cyc, rsp_cyc - prev_en_cyc);
        end
    endtask

    task automatic test_timeout;
        int s, e, w;
        s = rsp_cnt;
        rdy_delay = 0;
        issue(1'b0, 1'b0, 9'h010, 16'h0000, 16'h0000);
        wait_rsp(s);
        checks++;
        if (rsp_cyc - en_cyc !== 17 || got_to !== 1'b1 || got_data !== 16'h0000) begin
            errors++; $display("FAIL to_read: got lat=%0d to=%b data=%h want 17 1 0000", rsp_cyc - en_cyc, got_to, got_data);
        end
        s = rsp_cnt; e = en_cnt; w = we_cnt;
        issue(1'b1, 1'b1, 9'h03D, 16'hFFFF, 16'hFFFF);
        wait_rsp(s);
        checks++;
        if (en_cnt - e !== 1 || we_cnt - w !== 0 || got_to !== 1'b1 || got_data !== 16'h0000) begin
            errors++; $display("FAIL to_rmw: got en=%0d we=%0d to=%b data=%h want 1 0 1 0000", en_cnt - e, we_cnt - w, got_to, got_data);
        end
        s = rsp_cnt;
        rdy_delay = 16;
        issue(1'b0, 1'b0, 9'h03D, 16'h0000, 16'h0000);
        wait_rsp(s);
        checks++;
        if (rsp_cyc - en_cyc !== 17 || got_to !== 1'b0 || got_data !== 16'hAB5D) begin
            errors++; $display("FAIL to_edge: got lat=%0d to=%b data=%h want 17 0 ab5d", rsp_cyc - en_cyc, got_to, got_data);
        end
    endtask

    task automatic test_reset_mid;
        int s;
        s = rsp_cnt;
        rdy_delay = 0;
        issue(1'b0, 1'b0, 9'h020, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, drpen_o, drpwe_o, rsp_valid, rsp_timeout} !== 5'b0 || {drpaddr_o, drpdi_o, rsp_rdata} !== '0) begin
            errors++; $display("FAIL mid_rst_out: got ctl=%b addr=%h di=%h rd=%h want all 0",
                {cmd_ready, drpen_o, drpwe_o, rsp_valid, rsp_timeout}, drpaddr_o, drpdi_o, rsp_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        stray_rdy = 1'b1;
        @(negedge clk);
        stray_rdy = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", cmd_ready); end
        repeat (25) @(negedge clk);
        checks++;
        if (rsp_cnt !== s) begin errors++; $display("FAIL mid_rst_norsp: got %0d responses want 0", rsp_cnt - s); end
        rdy_delay = 2;
        issue(1'b0, 1'b0, 9'h03D, 16'h0000, 16'h0000);
        wait_rsp(s);
        checks++;
        if (got_data !== 16'hAB5D || got_to !== 1'b0 || rsp_cyc - en_cyc !== 3) begin
            errors++; $display("FAIL mid_rst_next: got data=%h to=%b lat=%0d want ab5d 0 3", got_data, got_to, rsp_cyc - en_cyc);
        end
    endtask

    task automatic test_back_to_back;
        int s, a, n;
        s = rsp_cnt;
        @(negedge clk);
        stray_rdy = 1'b1;
        @(negedge clk);
        stray_rdy = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_cnt !== s || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL stray_idle: got rsp=%0d ready=%b want 0 1", rsp_cnt - s, cmd_ready);
        end
        a = acc_cnt; viol = 0; n = 0;
        rdy_delay = 2;
        cmd_write = 1'b0; cmd_rmw = 1'b0; cmd_addr = 9'h03D;
        cmd_valid = 1'b1;
        while (rsp_cnt < s + 3 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (acc_cnt - a !== 3 || rsp_cnt - s !== 3) begin
            errors++; $display("FAIL b2b_count: got acc=%0d rsp=%0d want 3 3", acc_cnt - a, rsp_cnt - s);
        end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL b2b_ready: got %0d handshake violations want 0", viol); end
        checks++;
        if (got_data !== 16'hAB5D || got_to !== 1'b0) begin
            errors++; $display("FAIL b2b_data: got %h to=%b want ab5d 0", got_data, got_to);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_rmw = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0; stray_rdy = 1'b0; rdy_delay = 0;
        test_reset;
        test_read;
        test_write;
        test_rmw;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
